// File: rtl/mmu.sv
// mmu: memory and I/O subsystem behind the two-stage RV32I core.
//   Dual-port synchronous RAM: port A serves instruction fetch, port B serves
//   data loads/stores. A small I/O block at 0x8000_0000 provides a GPIO output
//   register, an 8N1 UART transmitter and an optional 64-bit cycle counter.
//   Optional feature macro: MMU_CYCLE_COUNTER_EN (counter present when defined;
//   otherwise CYCLE_LO/HI read 0).
// Ports:
//   clk, resetb          clock, asynchronous active-low reset
//   im_addr / im_do      fetch address / instruction (1-cycle latency)
//   dm_addr, dm_di       data byte address, right-justified store data
//   dm_be, dm_we         lane-aligned byte enables (0 = idle), store select
//   dm_is_signed         sign-extend sub-word loads
//   dm_do                load result, valid the cycle after the request
//   gpio_out             GPIO output register
//   uart_tx              UART serial output, idle high
//
// UART FSM states:
//   state | meaning
//   IDLE  | line high, ready to accept a byte
//   START | start bit (low) for CLK_DIV cycles
//   DATA  | 8 data bits LSB first, CLK_DIV cycles each
//   STOP  | stop bit (high) for CLK_DIV cycles
module mmu #(
    parameter int RAM_WORDS = 2048,
    parameter     INIT_FILE = "",
    parameter int CLK_DIV   = 104,
    parameter int GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [31:0]       im_addr,
    output logic [31:0]       im_do,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_di,
    input  logic [3:0]        dm_be,
    input  logic              dm_we,
    input  logic              dm_is_signed,
    output logic [31:0]       dm_do,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              uart_tx
);
    localparam int L  = $clog2(RAM_WORDS);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);
    localparam logic [31:0]   NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic [31:0]  ram [RAM_WORDS];
    logic [L-1:0] im_idx, dm_idx;
    logic         sel_ram, sel_io, acc, st, ld;
    logic [31:0]  wdata;

    assign im_idx  = im_addr[L+1:2];
    assign dm_idx  = dm_addr[L+1:2];
    assign sel_ram = ~dm_addr[31];
    assign sel_io  = (dm_addr[31:4] == 28'h8000000);
    assign acc     = |dm_be;
    assign st      = acc & dm_we;
    assign ld      = acc & ~dm_we;
    assign wdata   = dm_di << {dm_addr[1:0], 3'b000};

    // Port B: byte-lane writes plus registered read (no reset, BRAM-friendly).
    logic [31:0] ram_q;
    always_ff @(posedge clk) begin
        if (st && sel_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (dm_be[b]) ram[dm_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        ram_q <= ram[dm_idx];
    end

    // Port A: old data on same-cycle collision falls out of non-blocking reads.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) im_do <= NOP;
        else         im_do <= ram[im_idx];
    end

    // Cycle counter
    logic [63:0] cyc;
`ifdef MMU_CYCLE_COUNTER_EN
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) cyc <= '0;
        else         cyc <= cyc + 64'd1;
    end
`else
    assign cyc = '0;
`endif

    // UART
    uart_state_t  state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]   idx, idx_n;
    logic [7:0]   shr, shr_n;
    logic         busy, uart_start;

    assign busy       = (state != IDLE);
    assign uart_start = st && sel_io && (dm_addr[3:2] == 2'd1) && dm_be[0] && !busy;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shr   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shr   <= shr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shr_n   = shr;
        uart_tx = 1'b1;
        unique case (state)
            IDLE: begin
                if (uart_start) begin
                    state_n = START;
                    cnt_n   = DIV_M1;
                    shr_n   = dm_di[7:0];
                end
            end
            START: begin
                uart_tx = 1'b0;
                if (cnt == '0) begin
                    state_n = DATA;
                    cnt_n   = DIV_M1;
                    idx_n   = 3'd0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                uart_tx = shr[idx];
                if (cnt == '0) begin
                    cnt_n = DIV_M1;
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 3'd1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // GPIO: merge written bytes into a 32-bit view, keep the low GPIO_W bits.
    logic [31:0] gpio_nxt;
    always_comb begin
        gpio_nxt = 32'(gpio_out);
        for (int b = 0; b < 4; b++) begin
            if (dm_be[b]) gpio_nxt[8*b +: 8] = wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) gpio_out <= '0;
        else if (st && sel_io && dm_addr[3:2] == 2'd0) gpio_out <= gpio_nxt[GPIO_W-1:0];
    end

    // Load path: register the word plus the formatting controls.
    logic [31:0] io_rd, io_q;
    always_comb begin
        unique case (dm_addr[3:2])
            2'd0:    io_rd = 32'(gpio_out);
            2'd1:    io_rd = {31'b0, busy};
            2'd2:    io_rd = cyc[31:0];
            default: io_rd = cyc[63:32];
        endcase
    end

    logic [3:0] ld_be;
    logic [1:0] ld_off;
    logic       ld_sgn, ld_ram, ld_io;
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ld_be  <= '0;
            ld_off <= '0;
            ld_sgn <= 1'b0;
            ld_ram <= 1'b0;
            ld_io  <= 1'b0;
            io_q   <= '0;
        end else begin
            ld_be  <= ld ? dm_be : 4'b0;
            ld_off <= dm_addr[1:0];
            ld_sgn <= dm_is_signed;
            ld_ram <= sel_ram;
            ld_io  <= sel_io;
            io_q   <= io_rd;
        end
    end

    logic [31:0] ld_word, ld_sh;
    assign ld_word = ld_ram ? ram_q : (ld_io ? io_q : 32'b0);
    assign ld_sh   = ld_word >> {ld_off, 3'b000};

    always_comb begin
        case ($countones(ld_be))
            0:       dm_do = 32'b0;
            1:       dm_do = {{24{ld_sgn & ld_sh[7]}},  ld_sh[7:0]};
            2:       dm_do = {{16{ld_sgn & ld_sh[15]}}, ld_sh[15:0]};
            default: dm_do = ld_sh;
        endcase
    end

    logic unused_ok;
    assign unused_ok = ^{im_addr, dm_addr, gpio_nxt};
endmodule
